id_scoreboard: RTL
==================

# id_scoreboard

Register-hazard scoreboard and issue controller between the decode stage and the execute/memory units. It tracks which of the 32 integer registers have an in-flight write and stalls decode on RAW/WAW hazards and outstanding-write overflow. It also sequences a drain: it blocks issue until all writes have retired, which `ebreak`, fence and CSR handling use. It owns the decode-to-execute valid/ready handshake and exposes busy state for debug.

## Interface
- `REG_ADDR_WIDTH`, 5: register address width; 2**REG_ADDR_WIDTH busy bits.
- `MAX_OUTSTANDING`, 4: maximum simultaneously busy registers, range 1..31.
- `WB_BYPASS`, 1: 1 = a register being written back this cycle is treated as not busy for the hazard check.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  decode holds a valid instruction.
- `rs1_used`, `rs2_used`  in  1  instruction reads rs1 / rs2.
- `rs1_addr`, `rs2_addr`  in  REG_ADDR_WIDTH  source registers.
- `rd_wen`  in  1  instruction writes rd.
- `rd_addr`  in  REG_ADDR_WIDTH  destination register.
- `ex_ready`  in  1  execute can accept an instruction.
- `wb_valid`  in  1  a register write retires this cycle.
- `wb_waddr`  in  REG_ADDR_WIDTH  retiring register.
- `kill`  in  1  squash all in-flight writes (redirect/exception).
- `drain_req`  in  1  level; request to block issue until empty.
- `id_ready`  out  1  decode may advance (combinational).
- `issue_fire`  out  1  instruction issued this cycle (combinational).
- `stall_raw`, `stall_waw`, `stall_full`, `stall_drain`  out  1  stall reasons (combinational).
- `busy_vec`  out  2**REG_ADDR_WIDTH  registered busy bits; bit 0 is always 0.
- `outstanding`  out  $clog2(MAX_OUTSTANDING+1)  registered count of busy bits.
- `drain_done`  out  1  registered one-cycle pulse.
- `err_spurious_wb`  out  1  registered one-cycle pulse.

## Operation
- Effective busy: `eb[r] = busy[r] & ~(WB_BYPASS & wb_valid & wb_waddr==r)`.
- `stall_raw = id_valid & ((rs1_used & rs1_addr!=0 & eb[rs1_addr]) | (rs2_used & rs2_addr!=0 & eb[rs2_addr]))`.
- `stall_waw = id_valid & rd_wen & rd_addr!=0 & eb[rd_addr]`.
- `stall_full = id_valid & rd_wen & rd_addr!=0 & (outstanding - wb_dec) == MAX_OUTSTANDING`.
  - `wb_dec = wb_valid & wb_waddr!=0 & busy[wb_waddr]`.
  - `wb_dec` is applied only when WB_BYPASS=1; otherwise `outstanding` is used unmodified.
- `stall_drain = id_valid & (state != RUN)`.
- `id_ready = ex_ready & ~(stall_raw|stall_waw|stall_full|stall_drain)`.
- `issue_fire = id_valid & id_ready`.
- Set: `issue_fire & rd_wen & rd_addr!=0` sets `busy[rd_addr]`.
- Clear: `wb_valid & wb_waddr!=0 & busy[wb_waddr]` clears that bit.
- Set and clear of the same register in one cycle: the set wins and the bit stays 1. `outstanding` is unchanged.
- `outstanding` next = current + set − clear, and always equals popcount(busy_vec).
- Write-back to x0 is ignored.
- Write-back to a non-busy register does not change state and pulses `err_spurious_wb` the next cycle.
- `kill`: busy_vec and outstanding go to 0 next cycle and override any same-cycle set or clear. Issue in the kill cycle is still allowed by the handshake, but its set is discarded.
- FSM, reset state RUN:
  - RUN → DRAIN when `drain_req`.
  - DRAIN → DONE when the next-state outstanding is 0, or on `kill`.
  - DONE: `drain_done` = 1 for this single cycle; DONE → RUN if `drain_req` is 0, otherwise → HOLD.
  - HOLD → RUN when `drain_req` is 0.
  - Issue is blocked in DRAIN, DONE and HOLD.
- `drain_req` while outstanding is 0: RUN → DRAIN → DONE. `drain_done` rises 2 cycles after `drain_req`.

## Timing
- Hazard and handshake outputs are combinational from inputs plus registered state, with no added latency.
- A busy bit is visible on `busy_vec` the cycle after `issue_fire`.
- A dependent instruction issues in the same cycle as the producing write-back when WB_BYPASS=1, and one cycle later when WB_BYPASS=0.
- Reset values: busy_vec=0, outstanding=0, state=RUN, drain_done=0, err_spurious_wb=0.
- Reset mid-drain returns to RUN with no `drain_done` pulse.
- `kill` and `rst` in the same cycle: `rst` wins, and the result is identical.

## Test plan
- Issue `add x5` (rd=5); next cycle `sub` with rs1=5 → `stall_raw`=1, `id_ready`=0. Then wb_valid, wb_waddr=5 → with WB_BYPASS=1, `issue_fire`=1 in that same cycle; busy_vec[5]=0 the next cycle.
- Issue 4 writes to x1..x4 (MAX_OUTSTANDING=4). A 5th write to x6 → `stall_full`=1. Retiring x2 in the same cycle → the x6 write issues; outstanding stays 4.
- Issue to x7 in the same cycle as wb to x7 while x7 is busy → with WB_BYPASS=1, busy_vec[7] stays 1 and outstanding is unchanged. With WB_BYPASS=0 → `stall_waw`=1.
- rd=0 and rs=0 instructions never stall and never set a bit. wb to x9 while not busy → `err_spurious_wb` pulses 1 cycle, no state change.
- x3 busy, `drain_req`=1 → `stall_drain`=1. wb x3 → `drain_done` pulses the following cycle. Hold `drain_req` → stays in HOLD. Release → issue resumes.
- x1, x2 busy plus simultaneous issue to x8 and `kill` → busy_vec=0, outstanding=0. Assert `rst` during DRAIN → state RUN, no `drain_done`.

Source files
------------

// File: rtl/id_scoreboard.sv
// Register-hazard scoreboard and issue controller between decode and execute.
// Tracks in-flight register writes, stalls on RAW/WAW/full, and sequences drains.
module id_scoreboard #(
   parameter int unsigned REG_ADDR_WIDTH  = 5,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned WB_BYPASS       = 1
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       id_valid,
   input  logic                                       rs1_used,
   input  logic                                       rs2_used,
   input  logic [REG_ADDR_WIDTH-1:0]                  rs1_addr,
   input  logic [REG_ADDR_WIDTH-1:0]                  rs2_addr,
   input  logic                                       rd_wen,
   input  logic [REG_ADDR_WIDTH-1:0]                  rd_addr,
   input  logic                                       ex_ready,
   input  logic                                       wb_valid,
   input  logic [REG_ADDR_WIDTH-1:0]                  wb_waddr,
   input  logic                                       kill,
   input  logic                                       drain_req,
   output logic                                       id_ready,
   output logic                                       issue_fire,
   output logic                                       stall_raw,
   output logic                                       stall_waw,
   output logic                                       stall_full,
   output logic                                       stall_drain,
   output logic [(2**REG_ADDR_WIDTH)-1:0]             busy_vec,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]       outstanding,
   output logic                                       drain_done,
   output logic                                       err_spurious_wb
);

   localparam int unsigned NumRegs  = 2**REG_ADDR_WIDTH;
   localparam int unsigned CntWidth = $clog2(MAX_OUTSTANDING+1);

   typedef enum logic [1:0] {StRun, StDrain, StDone, StHold} state_e;

   state_e               state_q, state_d;
   logic [NumRegs-1:0]   busy_q, busy_d, byp_mask, eb;
   logic [CntWidth-1:0]  cnt_q, cnt_d, cnt_eff;
   logic                 drain_done_q, err_q;
   logic                 wb_clr, wb_spur, rd_nz, rs1_nz, rs2_nz, set_busy;

   assign rd_nz   = (rd_addr != '0);
   assign rs1_nz  = (rs1_addr != '0);
   assign rs2_nz  = (rs2_addr != '0);
   assign wb_clr  = wb_valid & (wb_waddr != '0) & busy_q[wb_waddr];
   assign wb_spur = wb_valid & (wb_waddr != '0) & ~busy_q[wb_waddr];

   // A register retiring this cycle is hidden from the hazard check when bypassing.
   always_comb begin
      byp_mask = '0;
      if ((WB_BYPASS != 0) && wb_valid) byp_mask[wb_waddr] = 1'b1;
   end

   assign eb      = busy_q & ~byp_mask;
   assign cnt_eff = (WB_BYPASS != 0) ? (cnt_q - CntWidth'(wb_clr)) : cnt_q;

   assign stall_raw   = id_valid & ((rs1_used & rs1_nz & eb[rs1_addr]) |
                                    (rs2_used & rs2_nz & eb[rs2_addr]));
   assign stall_waw   = id_valid & rd_wen & rd_nz & eb[rd_addr];
   assign stall_full  = id_valid & rd_wen & rd_nz & (cnt_eff == CntWidth'(MAX_OUTSTANDING));
   assign stall_drain = id_valid & (state_q != StRun);
   assign id_ready    = ex_ready & ~(stall_raw | stall_waw | stall_full | stall_drain);
   assign issue_fire  = id_valid & id_ready;
   assign set_busy    = issue_fire & rd_wen & rd_nz;

   // Set is applied after clear so a same-register set/clear leaves the bit high.
   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q + CntWidth'(set_busy) - CntWidth'(wb_clr);
      if (wb_clr) busy_d[wb_waddr] = 1'b0;
      if (set_busy) busy_d[rd_addr] = 1'b1;
      busy_d[0] = 1'b0;
      if (kill) begin
         busy_d = '0;
         cnt_d  = '0;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StRun:   if (drain_req) state_d = StDrain;
         StDrain: if ((cnt_d == '0) || kill) state_d = StDone;
         StDone:  state_d = drain_req ? StHold : StRun;
         StHold:  if (!drain_req) state_d = StRun;
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StRun;
         busy_q       <= '0;
         cnt_q        <= '0;
         drain_done_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         busy_q       <= busy_d;
         cnt_q        <= cnt_d;
         drain_done_q <= (state_d == StDone);
         err_q        <= wb_spur;
      end
   end

   assign busy_vec        = busy_q;
   assign outstanding     = cnt_q;
   assign drain_done      = drain_done_q;
   assign err_spurious_wb = err_q;

endmodule
